// File: rtl/irrigation_pkg.sv
// Shared types and defaults for the irrigation scheduler: FSM state encoding,
// default timing constants and a counter-width legality helper.
package irrigation_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DRIP     = 3'd1,
      S_SPRAY    = 3'd2,
      S_COOLDOWN = 3'd3,
      S_FAULT    = 3'd4
   } stateT;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
   localparam int DEFAULT_MIN_ON          = 16;
   localparam int DEFAULT_MAX_ON          = 256;
   localparam int DEFAULT_COOLDOWN        = 32;
   localparam int DEFAULT_CNT_W           = 9;

   // True when a CNT_W-bit counter can reach every terminal count it is compared against.
   function automatic bit cntWidthOk(input int cntW, input int maxOn, input int coolDown);
      longint limit;
      limit = (maxOn > coolDown) ? longint'(maxOn) : longint'(coolDown);
      return (longint'(1) << cntW) > limit;
   endfunction

endpackage

// File: rtl/irrigation_scheduler_debounce.sv
// Two-flop synchroniser followed by a debouncer that accepts a new level only after
// DEBOUNCE_CYCLES consecutive synchronised samples disagree with the current one.
module sensor_debounce
   import irrigation_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic rawIn,
   output logic debounced
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST_SAMPLE = CW'(DEBOUNCE_CYCLES - 1);

   logic syncA;
   logic syncB;
   logic [CW-1:0] diffCount;

   // Any agreeing sample restarts the run, so short glitches never reach the output.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         syncA     <= 1'b0;
         syncB     <= 1'b0;
         diffCount <= '0;
         debounced <= 1'b0;
      end else begin
         syncA <= rawIn;
         syncB <= syncA;
         if (syncB == debounced) begin
            diffCount <= '0;
         end else if (diffCount == LAST_SAMPLE) begin
            debounced <= syncB;
            diffCount <= '0;
         end else begin
            diffCount <= diffCount + CW'(1);
         end
      end
   end

endmodule

// File: rtl/irrigation_scheduler.sv
// Irrigation sequencer: debounced field and tank sensors drive a timed drip/spray FSM
// with a forced rest, a fail-safe fault state and a hysteretic tank inlet valve.
module irrigation_scheduler
   import irrigation_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int MIN_ON          = DEFAULT_MIN_ON,
   parameter int MAX_ON          = DEFAULT_MAX_ON,
   parameter int COOLDOWN        = DEFAULT_COOLDOWN,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       UmidadeAr,
   input  logic       UmidadeSolo,
   input  logic       Temperatura,
   input  logic       High,
   input  logic       Medium,
   input  logic       Low,
   output logic       Gotejamento,
   output logic       Aspersao,
   output logic       ValvulaEntrada,
   output logic       Erro,
   output logic       Alarme,
   output logic [2:0] Estado
);

   localparam logic [CNT_W-1:0] MIN_ON_LAST   = CNT_W'(MIN_ON - 1);
   localparam logic [CNT_W-1:0] MAX_ON_LAST   = CNT_W'(MAX_ON - 1);
   localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN - 1);

   if (!cntWidthOk(CNT_W, MAX_ON, COOLDOWN)) begin : gCntWidthCheck
      $error("irrigation_scheduler: CNT_W too narrow for MAX_ON/COOLDOWN");
   end

   logic [5:0] rawSensors;
   logic [5:0] debSensors;
   logic airD, soilD, tempD, highD, medD, lowD;

   assign rawSensors = {UmidadeAr, UmidadeSolo, Temperatura, High, Medium, Low};

   for (genvar i = 0; i < 6; i++) begin : gDebounce
      sensor_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) uDebounce (
         .clock    (Clock),
         .reset    (Reset),
         .rawIn    (rawSensors[i]),
         .debounced(debSensors[i])
      );
   end

   assign {airD, soilD, tempD, highD, medD, lowD} = debSensors;

   logic errTerm;
   logic almTerm;
   logic dripReq;
   logic sprayReq;

   // Probe consistency: high without medium, or medium without low, cannot be a real level.
   assign errTerm  = (highD & ~medD) | (medD & ~lowD);
   assign almTerm  = ~lowD | errTerm;
   assign dripReq  = ~soilD & airD & (~medD | tempD);
   assign sprayReq = ~soilD & (~airD | (medD & ~tempD));

   stateT            state;
   stateT            nextState;
   logic [CNT_W-1:0] count;
   logic             dripNext;
   logic             sprayNext;

   // State register; the actuator outputs are registered alongside it so they
   // always agree with the state code and can never overlap.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= S_IDLE;
         count       <= '0;
         Gotejamento <= 1'b0;
         Aspersao    <= 1'b0;
      end else begin
         state       <= nextState;
         Gotejamento <= dripNext;
         Aspersao    <= sprayNext;
         if (nextState != state) begin
            count <= '0;
         end else if (count != '1) begin
            count <= count + CNT_W'(1);
         end
      end
   end

   // Alarm always wins; a burst ends at the cap or once its request is gone after the minimum.
   always_comb begin
      nextState = state;
      case (state)
         S_IDLE: begin
            if (almTerm) begin
               nextState = S_FAULT;
            end else if (sprayReq) begin
               nextState = S_SPRAY;
            end else if (dripReq) begin
               nextState = S_DRIP;
            end
         end
         S_DRIP: begin
            if (almTerm) begin
               nextState = S_FAULT;
            end else if (count == MAX_ON_LAST) begin
               nextState = S_COOLDOWN;
            end else if ((count >= MIN_ON_LAST) && !dripReq) begin
               nextState = S_COOLDOWN;
            end
         end
         S_SPRAY: begin
            if (almTerm) begin
               nextState = S_FAULT;
            end else if (count == MAX_ON_LAST) begin
               nextState = S_COOLDOWN;
            end else if ((count >= MIN_ON_LAST) && !sprayReq) begin
               nextState = S_COOLDOWN;
            end
         end
         S_COOLDOWN: begin
            if (almTerm) begin
               nextState = S_FAULT;
            end else if (count == COOLDOWN_LAST) begin
               nextState = S_IDLE;
            end
         end
         S_FAULT: begin
            if (!almTerm) begin
               nextState = S_COOLDOWN;
            end
         end
         default: nextState = S_FAULT;
      endcase
   end

   always_comb begin
      dripNext  = 1'b0;
      sprayNext = 1'b0;
      dripNext  = (nextState == S_DRIP);
      sprayNext = (nextState == S_SPRAY);
   end

   assign Estado = state;

   // Inlet valve opens below medium and closes at high (or on a probe error), holding in between.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Erro           <= 1'b0;
         Alarme         <= 1'b0;
         ValvulaEntrada <= 1'b0;
      end else begin
         Erro   <= errTerm;
         Alarme <= almTerm;
         if (errTerm | highD) begin
            ValvulaEntrada <= 1'b0;
         end else if (!medD) begin
            ValvulaEntrada <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Self-checking bench for irrigation_scheduler: directed sequences, a tank-level
// vector table and a randomized run against a cycle-level reference model.
module tb_irrigation_scheduler;

   localparam int DEB   = 4;
   localparam int MINON = 16;
   localparam int MAXON = 64;
   localparam int COOL  = 32;
   localparam int CNTW  = 9;

   // Input vector order: {UmidadeAr, UmidadeSolo, Temperatura, High, Medium, Low}
   localparam logic [5:0] DRIP_IN     = 6'b101011;
   localparam logic [5:0] SPRAY_IN    = 6'b000011;
   localparam logic [5:0] SPRAY_DRY   = 6'b000010;
   localparam logic [5:0] IDLE_IN     = 6'b111011;
   localparam logic [5:0] DRIP_WET_IN = 6'b111011;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       UmidadeAr, UmidadeSolo, Temperatura, High, Medium, Low;
   logic       Gotejamento, Aspersao, ValvulaEntrada, Erro, Alarme;
   logic [2:0] Estado;

   int total = 0;
   int bad   = 0;

   always #5 Clock = ~Clock;

   irrigation_scheduler #(
      .DEBOUNCE_CYCLES(DEB),
      .MIN_ON         (MINON),
      .MAX_ON         (MAXON),
      .COOLDOWN       (COOL),
      .CNT_W          (CNTW)
   ) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .UmidadeAr     (UmidadeAr),
      .UmidadeSolo   (UmidadeSolo),
      .Temperatura   (Temperatura),
      .High          (High),
      .Medium        (Medium),
      .Low           (Low),
      .Gotejamento   (Gotejamento),
      .Aspersao      (Aspersao),
      .ValvulaEntrada(ValvulaEntrada),
      .Erro          (Erro),
      .Alarme        (Alarme),
      .Estado        (Estado)
   );

   typedef struct {
      logic lo;
      logic med;
      logic hi;
      logic expErro;
      logic expAlarme;
      logic expValve;
   } tankVecT;

   tankVecT tankVec[8];

   // Reference model: debounce expressed as "last DEB seen samples all disagree",
   // FSM expressed as phase plus time spent in it.
   logic [5:0] histQ[$];
   logic [5:0] mDeb;
   int         mPhase;
   int         mElapsed;
   logic       mGot, mAsp, mValve, mErro, mAlarme;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] v);
      {UmidadeAr, UmidadeSolo, Temperatura, High, Medium, Low} = v;
   endtask

   task automatic doReset();
      Reset = 1'b1;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
   endtask

   task automatic waitEstado(input logic [2:0] code, input int bound, input string name);
      int n = 0;
      while (Estado !== code && n < bound) begin
         @(negedge Clock);
         n++;
      end
      checkOutput(name, Estado, code);
   endtask

   task automatic countEstado(input logic [2:0] code, input int expLen, input string name);
      int n = 0;
      while (Estado === code && n < 1000) begin
         n++;
         @(negedge Clock);
      end
      checkOutput(name, n, expLen);
   endtask

   task automatic modelReset();
      histQ = {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
      mDeb = '0;
      mPhase = 0;
      mElapsed = 0;
      {mGot, mAsp, mValve, mErro, mAlarme} = '0;
   endtask

   task automatic modelStep(input logic [5:0] x);
      logic ar, solo, temp, hi, med, lo;
      logic err, alm, dripR, sprayR, want, differs;
      int nxt;
      {ar, solo, temp, hi, med, lo} = mDeb;
      err    = (hi && !med) || (med && !lo);
      alm    = !lo || err;
      dripR  = !solo && ar && (!med || temp);
      sprayR = !solo && (!ar || (med && !temp));
      nxt = mPhase;
      case (mPhase)
         0: begin
            if (alm) nxt = 4;
            else if (sprayR) nxt = 2;
            else if (dripR) nxt = 1;
         end
         1, 2: begin
            want = (mPhase == 1) ? dripR : sprayR;
            if (alm) nxt = 4;
            else if (mElapsed + 1 >= MAXON) nxt = 3;
            else if (mElapsed + 1 >= MINON && !want) nxt = 3;
         end
         3: begin
            if (alm) nxt = 4;
            else if (mElapsed + 1 == COOL) nxt = 0;
         end
         default: begin
            if (!alm) nxt = 3;
         end
      endcase
      mElapsed = (nxt == mPhase) ? mElapsed + 1 : 0;
      mPhase   = nxt;
      mGot     = (nxt == 1);
      mAsp     = (nxt == 2);
      mErro    = err;
      mAlarme  = alm;
      if (err || hi) mValve = 1'b0;
      else if (!med) mValve = 1'b1;
      for (int b = 0; b < 6; b++) begin
         differs = 1'b1;
         for (int k = 1; k <= DEB; k++) begin
            if (histQ[k][b] == mDeb[b]) differs = 1'b0;
         end
         if (differs) mDeb[b] = ~mDeb[b];
      end
      histQ.push_front(x);
      if (histQ.size() > 8) void'(histQ.pop_back());
   endtask

   initial begin
      logic [5:0] x;
      logic [7:0] gotV, wantV;
      int n;
      int changes;
      int randBad;

      tankVec[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tankVec[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tankVec[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tankVec[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tankVec[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tankVec[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tankVec[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tankVec[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      // Reset values
      Reset = 1'b1;
      applyStimulus(DRIP_IN);
      repeat (2) @(negedge Clock);
      checkOutput("resetGot", Gotejamento, 0);
      checkOutput("resetAsp", Aspersao, 0);
      checkOutput("resetValve", ValvulaEntrada, 0);
      checkOutput("resetErro", Erro, 0);
      checkOutput("resetAlarme", Alarme, 0);
      checkOutput("resetEstado", Estado, 0);
      Reset = 1'b0;

      // Drip burst, soil turns wet early: minimum on-time, then full rest
      @(negedge Clock);
      checkOutput("alarmAfterReset", Alarme, 1);
      waitEstado(3'd1, 200, "enterDrip");
      checkOutput("dripGot", Gotejamento, 1);
      checkOutput("dripAlarmLow", Alarme, 0);
      checkOutput("dripAspOff", Aspersao, 0);
      n = 0;
      while (Estado === 3'd1 && n < 1000) begin
         n++;
         if (n == 3) applyStimulus(DRIP_WET_IN);
         @(negedge Clock);
      end
      checkOutput("dripMinOnLen", n, MINON);
      checkOutput("coolAfterDrip", Estado, 3);
      checkOutput("coolGotOff", Gotejamento, 0);
      countEstado(3'd3, COOL, "coolLenAfterDrip");
      checkOutput("idleAfterCool", Estado, 0);

      // Soil held dry: burst capped at MAX_ON even with the request still active
      applyStimulus(DRIP_IN);
      doReset();
      waitEstado(3'd1, 200, "enterDripCap");
      n = 0;
      while (Gotejamento === 1'b1 && n < 200) begin
         n++;
         @(negedge Clock);
      end
      checkOutput("maxOnBurstLen", n, MAXON);
      checkOutput("coolAfterCap", Estado, 3);

      // Spray interrupted by low water: fault overrides minimum on-time
      applyStimulus(SPRAY_IN);
      doReset();
      waitEstado(3'd2, 200, "enterSpray");
      checkOutput("sprayAsp", Aspersao, 1);
      checkOutput("sprayGotOff", Gotejamento, 0);
      repeat (2) @(negedge Clock);
      applyStimulus(SPRAY_DRY);
      waitEstado(3'd4, 12, "sprayToFault");
      checkOutput("faultAspOff", Aspersao, 0);
      checkOutput("faultAlarme", Alarme, 1);
      applyStimulus(SPRAY_IN);
      waitEstado(3'd3, 12, "faultToCool");
      countEstado(3'd3, COOL, "coolLenAfterFault");
      checkOutput("idleAfterFaultCool", Estado, 0);

      // Tank level table: error flags and inlet valve hysteresis
      doReset();
      for (int i = 0; i < 8; i++) begin
         applyStimulus({1'b1, 1'b1, 1'b0, tankVec[i].hi, tankVec[i].med, tankVec[i].lo});
         repeat (10) @(negedge Clock);
         checkOutput($sformatf("tankErro[%0d]", i), Erro, tankVec[i].expErro);
         checkOutput($sformatf("tankAlarme[%0d]", i), Alarme, tankVec[i].expAlarme);
         checkOutput($sformatf("tankValve[%0d]", i), ValvulaEntrada, tankVec[i].expValve);
         checkOutput($sformatf("tankFault[%0d]", i), (Estado === 3'd4), tankVec[i].expAlarme);
      end

      // Short soil glitch in IDLE is ignored
      applyStimulus(IDLE_IN);
      doReset();
      waitEstado(3'd4, 10, "glitchFault");
      waitEstado(3'd3, 20, "glitchCool");
      waitEstado(3'd0, 60, "glitchIdle");
      applyStimulus(DRIP_IN);
      repeat (3) @(negedge Clock);
      applyStimulus(IDLE_IN);
      changes = 0;
      repeat (12) begin
         @(negedge Clock);
         if (Estado !== 3'd0 || Gotejamento !== 1'b0) changes++;
      end
      checkOutput("glitchIgnored", changes, 0);

      // Asynchronous reset mid-drip
      applyStimulus(DRIP_IN);
      waitEstado(3'd1, 40, "dripBeforeReset");
      checkOutput("preResetValve", ValvulaEntrada, 1);
      #2 Reset = 1'b1;
      #1;
      checkOutput("asyncRstGot", Gotejamento, 0);
      checkOutput("asyncRstValve", ValvulaEntrada, 0);
      checkOutput("asyncRstEstado", Estado, 0);
      checkOutput("asyncRstAlarme", Alarme, 0);
      @(negedge Clock);
      Reset = 1'b0;
      checkOutput("releaseIdle", Estado, 0);
      @(negedge Clock);
      checkOutput("releaseFault", Estado, 4);

      // Randomized run against the reference model
      x = IDLE_IN;
      applyStimulus(x);
      Reset = 1'b1;
      modelReset();
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      modelStep(x);
      randBad = 0;
      for (int i = 0; i < 2500 && randBad < 20; i++) begin
         @(negedge Clock);
         gotV  = {Gotejamento, Aspersao, ValvulaEntrada, Erro, Alarme, Estado};
         wantV = {mGot, mAsp, mValve, mErro, mAlarme, 3'(mPhase)};
         if (gotV !== wantV) randBad++;
         checkOutput($sformatf("randomVsModel@%0d", i), gotV, wantV);
         for (int b = 0; b < 6; b++) begin
            if ($urandom_range((b < 3) ? 149 : 24, 0) == 0) x[b] = ~x[b];
         end
         applyStimulus(x);
         modelStep(x);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
